// File: rtl/alu_rs_pkg.sv
// Shared constants and op codes for the ALU reservation station slice.
package alu_rs_pkg;

  localparam int RS_SIZE_DEF = 8;
  localparam int TAG_W_DEF   = 5;
  localparam int OP_W        = 7;
  localparam int XLEN        = 32;

  typedef enum logic [OP_W-1:0] {
    OP_NONE = 7'd0,
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU
  } alu_op_e;

endpackage

// File: rtl/alu_rs_prio_enc.sv
// Lowest-set-bit priority encoder used for free-slot and ready-slot selection.
module rs_prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  // Scanning downward lets the lowest set index win.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ops, snoops both CDBs for operands,
// and issues the lowest-index ready entry each cycle onto registered ALU inputs.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEF,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  input  logic             dis_valid,
  input  logic [6:0]       dis_op,
  input  logic [31:0]      dis_vi,
  input  logic [31:0]      dis_vj,
  input  logic [TAG_W-1:0] dis_qi,
  input  logic [TAG_W-1:0] dis_qj,
  input  logic             dis_qi_v,
  input  logic             dis_qj_v,
  input  logic [31:0]      dis_imm,
  input  logic [31:0]      dis_pc,
  input  logic [TAG_W-1:0] dis_rob,
  output logic             full_out,
  input  logic             alu_cdb_v,
  input  logic [TAG_W-1:0] alu_cdb_tag,
  input  logic [31:0]      alu_cdb_val,
  input  logic             lsb_cdb_v,
  input  logic [TAG_W-1:0] lsb_cdb_tag,
  input  logic [31:0]      lsb_cdb_val,
  output logic [6:0]       iss_op,
  output logic [31:0]      iss_vi,
  output logic [31:0]      iss_vj,
  output logic [31:0]      iss_imm,
  output logic [31:0]      iss_pc,
  output logic [TAG_W-1:0] iss_rob
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0] busy_q, busy_d, qiValid_q, qiValid_d, qjValid_q, qjValid_d;
  logic [6:0]         op_q  [RS_SIZE], op_d  [RS_SIZE];
  logic [31:0]        vi_q  [RS_SIZE], vi_d  [RS_SIZE];
  logic [31:0]        vj_q  [RS_SIZE], vj_d  [RS_SIZE];
  logic [31:0]        imm_q [RS_SIZE], imm_d [RS_SIZE];
  logic [31:0]        pc_q  [RS_SIZE], pc_d  [RS_SIZE];
  logic [TAG_W-1:0]   qi_q  [RS_SIZE], qi_d  [RS_SIZE];
  logic [TAG_W-1:0]   qj_q  [RS_SIZE], qj_d  [RS_SIZE];
  logic [TAG_W-1:0]   rob_q [RS_SIZE], rob_d [RS_SIZE];

  logic [6:0]       issOp_q, issOp_d;
  logic [31:0]      issVi_q, issVi_d, issVj_q, issVj_d, issImm_q, issImm_d, issPc_q, issPc_d;
  logic [TAG_W-1:0] issRob_q, issRob_d;

  logic [RS_SIZE-1:0] readyVec;
  logic [IDX_W-1:0]   freeIdx, issIdx;
  logic               freeFound, issFound, doDis, doIss;
  logic [31:0]        disVi, disVj;
  logic               disQiV, disQjV;

  assign full_out = &busy_q;
  assign readyVec = busy_q & ~qiValid_q & ~qjValid_q;

  rs_prio_enc #(.N(RS_SIZE), .IDX_W(IDX_W)) freeEnc (
    .vec_i(~busy_q), .idx_o(freeIdx), .found_o(freeFound)
  );

  rs_prio_enc #(.N(RS_SIZE), .IDX_W(IDX_W)) readyEnc (
    .vec_i(readyVec), .idx_o(issIdx), .found_o(issFound)
  );

  assign doDis = dis_valid & freeFound & ~clear_in;
  assign doIss = issFound & ~clear_in;

  // Operands arriving on a CDB in the dispatch cycle are captured immediately; ALU CDB has priority.
  always_comb begin
    disVi  = dis_vi;
    disQiV = dis_qi_v;
    if (dis_qi_v && alu_cdb_v && alu_cdb_tag == dis_qi) begin
      disVi  = alu_cdb_val;
      disQiV = 1'b0;
    end else if (dis_qi_v && lsb_cdb_v && lsb_cdb_tag == dis_qi) begin
      disVi  = lsb_cdb_val;
      disQiV = 1'b0;
    end
    disVj  = dis_vj;
    disQjV = dis_qj_v;
    if (dis_qj_v && alu_cdb_v && alu_cdb_tag == dis_qj) begin
      disVj  = alu_cdb_val;
      disQjV = 1'b0;
    end else if (dis_qj_v && lsb_cdb_v && lsb_cdb_tag == dis_qj) begin
      disVj  = lsb_cdb_val;
      disQjV = 1'b0;
    end
  end

  always_comb begin
    busy_d    = busy_q;
    qiValid_d = qiValid_q;
    qjValid_d = qjValid_q;
    op_d      = op_q;
    vi_d      = vi_q;
    vj_d      = vj_q;
    imm_d     = imm_q;
    pc_d      = pc_q;
    qi_d      = qi_q;
    qj_d      = qj_q;
    rob_d     = rob_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (busy_q[i] && qiValid_q[i]) begin
        if (alu_cdb_v && alu_cdb_tag == qi_q[i]) begin
          vi_d[i]      = alu_cdb_val;
          qiValid_d[i] = 1'b0;
        end else if (lsb_cdb_v && lsb_cdb_tag == qi_q[i]) begin
          vi_d[i]      = lsb_cdb_val;
          qiValid_d[i] = 1'b0;
        end
      end
      if (busy_q[i] && qjValid_q[i]) begin
        if (alu_cdb_v && alu_cdb_tag == qj_q[i]) begin
          vj_d[i]      = alu_cdb_val;
          qjValid_d[i] = 1'b0;
        end else if (lsb_cdb_v && lsb_cdb_tag == qj_q[i]) begin
          vj_d[i]      = lsb_cdb_val;
          qjValid_d[i] = 1'b0;
        end
      end
    end
    if (doIss) busy_d[issIdx] = 1'b0;
    // The free slot comes from pre-edge busy, so a slot issued this cycle is not reused yet.
    if (doDis) begin
      busy_d[freeIdx]    = 1'b1;
      op_d[freeIdx]      = dis_op;
      vi_d[freeIdx]      = disVi;
      vj_d[freeIdx]      = disVj;
      qiValid_d[freeIdx] = disQiV;
      qjValid_d[freeIdx] = disQjV;
      qi_d[freeIdx]      = dis_qi;
      qj_d[freeIdx]      = dis_qj;
      imm_d[freeIdx]     = dis_imm;
      pc_d[freeIdx]      = dis_pc;
      rob_d[freeIdx]     = dis_rob;
    end
    if (clear_in) busy_d = '0;
  end

  always_comb begin
    issOp_d  = issOp_q;
    issVi_d  = issVi_q;
    issVj_d  = issVj_q;
    issImm_d = issImm_q;
    issPc_d  = issPc_q;
    issRob_d = issRob_q;
    if (doIss) begin
      issOp_d  = op_q[issIdx];
      issVi_d  = vi_q[issIdx];
      issVj_d  = vj_q[issIdx];
      issImm_d = imm_q[issIdx];
      issPc_d  = pc_q[issIdx];
      issRob_d = rob_q[issIdx];
    end else begin
      issOp_d  = '0;
    end
  end

  // Everything holds while rdy_in is low, so the ALU keeps seeing the same op.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q    <= '0;
      qiValid_q <= '0;
      qjValid_q <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i]  <= '0;
        vi_q[i]  <= '0;
        vj_q[i]  <= '0;
        imm_q[i] <= '0;
        pc_q[i]  <= '0;
        qi_q[i]  <= '0;
        qj_q[i]  <= '0;
        rob_q[i] <= '0;
      end
      issOp_q  <= '0;
      issVi_q  <= '0;
      issVj_q  <= '0;
      issImm_q <= '0;
      issPc_q  <= '0;
      issRob_q <= '0;
    end else if (rdy_in) begin
      busy_q    <= busy_d;
      qiValid_q <= qiValid_d;
      qjValid_q <= qjValid_d;
      op_q      <= op_d;
      vi_q      <= vi_d;
      vj_q      <= vj_d;
      imm_q     <= imm_d;
      pc_q      <= pc_d;
      qi_q      <= qi_d;
      qj_q      <= qj_d;
      rob_q     <= rob_d;
      issOp_q   <= issOp_d;
      issVi_q   <= issVi_d;
      issVj_q   <= issVj_d;
      issImm_q  <= issImm_d;
      issPc_q   <= issPc_d;
      issRob_q  <= issRob_d;
    end
  end

  assign iss_op  = issOp_q;
  assign iss_vi  = issVi_q;
  assign iss_vj  = issVj_q;
  assign iss_imm = issImm_q;
  assign iss_pc  = issPc_q;
  assign iss_rob = issRob_q;

endmodule
